// File: rtl/fsx_frame_grabber_if.sv
// fsx_frame_grabber_if: 32-bit packed-pixel word stream with a last marker and valid/ready handshake.
interface fsx_frame_grabber_if;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    modport master (output out_data, out_valid, out_last, input out_ready);
    modport slave  (input out_data, out_valid, out_last, output out_ready);
endinterface

// File: rtl/fsx_frame_grabber.sv
// fsx_frame_grabber: grabs one FSX frame per cap_req, packs 4 pixels per word into a show-ahead FIFO and streams it out.
// Define FSX_FRAME_GRAB_SUM_EN to get a running 32-bit sum of the delivered words on frame_sum.
module fsx_frame_grabber #(
    parameter int H_RES           = 320,
    parameter int V_RES           = 200,
    parameter bit V_POL           = 1'b0,
    parameter int FIFO_DEPTH_LOG2 = 5
) (
    input  logic                       vga_clk,
    input  logic                       nreset,
    input  logic [2:0]                 pix_r,
    input  logic [2:0]                 pix_g,
    input  logic [1:0]                 pix_b,
    input  logic                       pix_vs,
    input  logic                       pix_de,
    input  logic                       cap_req,
    input  logic                       cap_clr,
    fsx_frame_grabber_if.master        dma,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic                       short_frame,
    output logic [31:0]                frame_sum
);
    localparam int TOTAL = H_RES * V_RES;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, DRAIN, DONE, ERROR} state_t;
    state_t state, state_nx;

    logic          vs_q, vs_qq, vs_edge;
    logic [CW-1:0] pix_cnt;
    logic [31:0]   pack;
    logic          wr_pend, wr_last;
    logic [32:0]   mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          full, rd, wr, drop, take, flush, last_pix;

    assign vs_edge  = (vs_q == V_POL) && (vs_qq != V_POL);
    assign full     = count == (AW+1)'(DEPTH);
    assign rd       = dma.out_valid && dma.out_ready;
    assign flush    = cap_clr && (state == ARMED || state == CAPTURE);
    // a completed word waits one cycle in pack; full is judged before any same-cycle read
    assign wr       = wr_pend && !full && !flush;
    assign drop     = wr_pend && full && !flush;
    assign take     = state == CAPTURE && pix_de && !vs_edge && !cap_clr;
    assign last_pix = pix_cnt == CW'(TOTAL - 1);

    assign dma.out_valid = count != '0;
    assign dma.out_data  = dma.out_valid ? mem[rptr][31:0] : '0;
    assign dma.out_last  = dma.out_valid && mem[rptr][32];
    assign busy          = state == ARMED || state == CAPTURE || dma.out_valid || wr_pend;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = cap_req ? ARMED : IDLE;
            ARMED:   state_nx = cap_clr ? IDLE : vs_edge ? CAPTURE : ARMED;
            CAPTURE: state_nx = cap_clr ? IDLE : (drop || vs_edge) ? ERROR : (take && last_pix) ? DRAIN : CAPTURE;
            DRAIN:   state_nx = drop ? ERROR : (!wr_pend && !dma.out_valid) ? DONE : DRAIN;
            default: state_nx = cap_clr ? IDLE : state;
        endcase
    end

    always_ff @(posedge vga_clk or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            vs_q        <= 1'b0;
            vs_qq       <= 1'b0;
            pix_cnt     <= '0;
            pack        <= '0;
            wr_pend     <= 1'b0;
            wr_last     <= 1'b0;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            state       <= state_nx;
            vs_q        <= pix_vs;
            vs_qq       <= vs_q;
            pix_cnt     <= (state == ARMED && vs_edge) ? '0 : take ? pix_cnt + CW'(1) : pix_cnt;
            if (take)
                pack[{pix_cnt[1:0], 3'b000} +: 8] <= {pix_r, pix_g, pix_b};
            wr_pend     <= take && (&pix_cnt[1:0]);
            wr_last     <= take && last_pix;
            wptr        <= flush ? '0 : wptr + AW'(wr);
            rptr        <= flush ? '0 : rptr + AW'(rd);
            count       <= flush ? '0 : count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
            done        <= !cap_clr && (done || (state == DRAIN && state_nx == DONE));
            overflow    <= !cap_clr && (overflow || drop);
            short_frame <= !cap_clr && (short_frame || (state == CAPTURE && vs_edge));
        end
    end

    always_ff @(posedge vga_clk)
        if (wr)
            mem[wptr] <= {wr_last, pack};

`ifdef FSX_FRAME_GRAB_SUM_EN
    always_ff @(posedge vga_clk or negedge nreset) begin
        if (!nreset)
            frame_sum <= '0;
        else
            frame_sum <= (cap_req || cap_clr) ? '0 : rd ? frame_sum + dma.out_data : frame_sum;
    end
`else
    assign frame_sum = '0;
`endif
endmodule

// File: tb/tb_fsx_frame_grabber.sv
// tb_fsx_frame_grabber: randomized frames checked against a packing/sum reference model; a second
// instance with a 2-word FIFO exercises overflow.
module tb_fsx_frame_grabber;
    localparam int H = 8, V = 2, N = H * V, NW = N / 4;
`ifdef FSX_FRAME_GRAB_SUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    logic        vga_clk = 1'b0, nreset = 1'b0;
    logic [2:0]  pix_r = '0, pix_g = '0;
    logic [1:0]  pix_b = '0;
    logic        pix_vs = 1'b1, pix_de = 1'b0, cap_req = 1'b0, cap_clr = 1'b0;
    logic        busy_a, done_a, ovf_a, short_a, busy_b, done_b, ovf_b, short_b;
    logic [31:0] sum_a, sum_b;
    int          mode_a = 1, mode_b = 1;
    int          n_chk = 0, n_pass = 0;
    logic [32:0] got_a[$], got_b[$];
    logic [7:0]  pix[N];
    logic [31:0] exp_w[NW];
    logic [31:0] exp_sum;
    logic        stall_a = 1'b0;
    logic [33:0] prev_a = '0;

    fsx_frame_grabber_if oa();
    fsx_frame_grabber_if ob();

    fsx_frame_grabber #(.H_RES(H), .V_RES(V), .V_POL(1'b0), .FIFO_DEPTH_LOG2(2)) dut (
        .vga_clk(vga_clk), .nreset(nreset), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pix_vs(pix_vs), .pix_de(pix_de), .cap_req(cap_req), .cap_clr(cap_clr), .dma(oa),
        .busy(busy_a), .done(done_a), .overflow(ovf_a), .short_frame(short_a), .frame_sum(sum_a));

    fsx_frame_grabber #(.H_RES(H), .V_RES(V), .V_POL(1'b0), .FIFO_DEPTH_LOG2(1)) dut_ovf (
        .vga_clk(vga_clk), .nreset(nreset), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pix_vs(pix_vs), .pix_de(pix_de), .cap_req(cap_req), .cap_clr(cap_clr), .dma(ob),
        .busy(busy_b), .done(done_b), .overflow(ovf_b), .short_frame(short_b), .frame_sum(sum_b));

    always #5 vga_clk = ~vga_clk;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            pix_de = 1'b0;
            {pix_r, pix_g, pix_b} = 8'($urandom);
            tick();
        end
    endtask

    task automatic pulse_req();
        cap_req = 1'b1;
        tick();
        cap_req = 1'b0;
    endtask

    task automatic pulse_clr();
        cap_clr = 1'b1;
        tick();
        cap_clr = 1'b0;
    endtask

    task automatic vsync();
        pix_de = 1'b0;
        pix_vs = 1'b0;
        tick();
        tick();
        pix_vs = 1'b1;
        idle(4);
    endtask

    task automatic send(int from, int to, bit gaps, int req_at);
        for (int i = from; i < to; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            {pix_r, pix_g, pix_b} = pix[i];
            pix_de = 1'b1;
            cap_req = (i == req_at);
            tick();
        end
        pix_de = 1'b0;
        cap_req = 1'b0;
    endtask

    task automatic new_frame(bit rnd);
        for (int i = 0; i < N; i++) pix[i] = rnd ? 8'($urandom) : 8'(i);
        exp_sum = '0;
        for (int w = 0; w < NW; w++) begin
            exp_w[w] = {pix[4*w+3], pix[4*w+2], pix[4*w+1], pix[4*w]};
            exp_sum += exp_w[w];
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && !done_a; i++) tick();
        check("done", done_a, 1);
    endtask

    task automatic check_words(string tag, input logic [32:0] q[$], int n, bit last_fin);
        check({tag, "_count"}, q.size(), n);
        for (int i = 0; i < n; i++)
            check(tag, i < q.size() ? 64'(q[i]) : 64'hDEAD_BEEF_0, {31'd0, last_fin && i == n - 1, exp_w[i]});
    endtask

    initial begin
        oa.out_ready = 1'b0;
        ob.out_ready = 1'b0;
        forever begin
            @(posedge vga_clk);
            #1;
            oa.out_ready = mode_a == 2 ? 1'($urandom_range(0, 1)) : mode_a[0];
            ob.out_ready = mode_b == 2 ? 1'($urandom_range(0, 1)) : mode_b[0];
        end
    end

    always @(negedge vga_clk) begin
        if (nreset && oa.out_valid && oa.out_ready) got_a.push_back({oa.out_last, oa.out_data});
        if (nreset && ob.out_valid && ob.out_ready) got_b.push_back({ob.out_last, ob.out_data});
        if (stall_a && nreset) check("stall_stable", {oa.out_valid, oa.out_last, oa.out_data}, prev_a);
        stall_a <= nreset && oa.out_valid && !oa.out_ready && !cap_clr;
        prev_a  <= {oa.out_valid, oa.out_last, oa.out_data};
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check("rst_flags", {busy_a, done_a, ovf_a, short_a, oa.out_valid, oa.out_last}, 0);
        check("rst_data", oa.out_data, 0);
        check("rst_sum", sum_a, 0);
        nreset = 1'b1;
        idle(3);

        // basic capture with index-valued pixels
        new_frame(1'b0);
        got_a.delete();
        pulse_req();
        check("armed_busy", busy_a, 1);
        vsync();
        send(0, N, 1'b0, -1);
        wait_done();
        check_words("basic", got_a, NW, 1'b1);
        check("basic_sum", sum_a, SUM_EN ? 32'h2420_1C18 : 32'h0);
        check("basic_ovf", ovf_a, 0);
        idle(2);
        check("basic_busy", busy_a, 0);

        // backpressure on main instance, overflow on the 2-deep instance
        pulse_clr();
        check("clr_done", done_a, 0);
        got_a.delete();
        got_b.delete();
        new_frame(1'b1);
        mode_a = 0;
        mode_b = 0;
        pulse_req();
        vsync();
        send(0, 8, 1'b0, -1);
        idle(3);
        check("ovf_b_early", ovf_b, 0);
        send(8, 12, 1'b0, -1);
        idle(3);
        check("ovf_b_set", ovf_b, 1);
        send(12, N, 1'b0, -1);
        idle(5);
        check("bp_valid", oa.out_valid, 1);
        check("bp_ovf", ovf_a, 0);
        check("bp_done", done_a, 0);
        check("bp_busy", busy_a, 1);
        check("bp_none_read", got_a.size(), 0);
        mode_a = 1;
        wait_done();
        check_words("bp", got_a, NW, 1'b1);
        mode_b = 1;
        idle(6);
        check_words("ovf", got_b, 2, 1'b0);
        check("ovf_b_done", done_b, 0);
        check("ovf_b_busy", busy_b, 0);

        // random frames with random gaps and random backpressure
        for (int f = 0; f < 5; f++) begin
            pulse_clr();
            got_a.delete();
            new_frame(1'b1);
            mode_a = 2;
            mode_b = 2;
            pulse_req();
            vsync();
            send(0, N, 1'b1, -1);
            wait_done();
            check_words("rnd", got_a, NW, 1'b1);
            check("rnd_sum", sum_a, SUM_EN ? exp_sum : 32'h0);
        end

        // short frame: vsync after 6 pixels
        pulse_clr();
        got_a.delete();
        new_frame(1'b1);
        mode_a = 1;
        mode_b = 1;
        pulse_req();
        vsync();
        send(0, 6, 1'b0, -1);
        idle(2);
        vsync();
        idle(4);
        check("sf_flag", short_a, 1);
        check("sf_done", done_a, 0);
        check_words("sf", got_a, 1, 1'b0);
        pulse_req();
        vsync();
        send(0, N, 1'b0, -1);
        idle(6);
        check("sf_ignore", got_a.size(), 1);
        check("sf_hold", short_a, 1);
        pulse_clr();
        check("sf_clr", short_a, 0);
        check("sf_busy", busy_a, 0);

        // arming mid-frame: nothing captured until the next vsync
        got_a.delete();
        new_frame(1'b1);
        send(0, N, 1'b0, 8);
        idle(3);
        check("arm_nowords", got_a.size(), 0);
        check("arm_busy", busy_a, 1);
        new_frame(1'b1);
        vsync();
        send(0, N, 1'b1, -1);
        wait_done();
        check_words("arm", got_a, NW, 1'b1);

        // asynchronous reset in the middle of a capture
        pulse_clr();
        got_a.delete();
        new_frame(1'b1);
        pulse_req();
        vsync();
        send(0, 5, 1'b0, -1);
        check("pre_rst_busy", busy_a, 1);
        #2 nreset = 1'b0;
        #1;
        check("arst_flags", {busy_a, done_a, ovf_a, short_a, oa.out_valid, oa.out_last}, 0);
        check("arst_data", oa.out_data, 0);
        check("arst_sum", sum_a, 0);
        tick();
        tick();
        nreset = 1'b1;
        idle(2);
        check("post_rst_busy", busy_a, 0);
        got_a.delete();
        vsync();
        send(0, N, 1'b0, -1);
        idle(6);
        check("post_rst_nowords", got_a.size(), 0);
        check("post_rst_idle", {busy_a, done_a, oa.out_valid}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
